// File: rtl/ysyx_22051145_core_mc_if.sv
// Instruction-fetch handshake between the multi-cycle core and memory.
// Request (valid/ready) and response (valid only) are separate phases.
interface ysyx_22051145_core_mc_if #(
  parameter int XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_inst;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_inst
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_inst
  );
endinterface

// File: rtl/ysyx_22051145_core_mc.sv
// Multi-cycle RV core: fetch over valid/ready, execute, writeback.
// Every retired instruction is reported on the commit port.
module ysyx_22051145_core_mc #(
  parameter int          XLEN     = 64,
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_22051145_core_mc_if.master imem,
  output logic                    commit_valid,
  output logic [XLEN-1:0]         commit_pc,
  output logic [31:0]             commit_inst,
  output logic [4:0]              commit_rd,
  output logic [XLEN-1:0]         commit_wdata,
  output logic                    halt,
  output logic                    fetch_err
);
  localparam int          SHW    = (XLEN == 64) ? 6 : 5;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IF_REQ, IF_WAIT, EXE, WB, HALT
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, npc_q;
  logic [31:0]     ir_q;
  logic [31:0]     wait_q;
  logic [XLEN-1:0] gpr [32];
  logic            timed_out;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rd, rs1, rs2;
  logic [XLEN-1:0] rv1, rv2;
  logic [XLEN-1:0] imm_i, imm_b, imm_u, imm_j;
  logic            is_lui, is_auipc, is_jal, is_jalr;
  logic            is_br, is_opi, is_op, is_opiw, is_opw;
  logic            w_ok, br_take;
  logic [XLEN-1:0] res, jaddr, npc;
  logic            wen, jump;
  logic [4:0]      wr_rd;

  function automatic logic [XLEN-1:0] alu(
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b,
    input logic [2:0]      f,
    input logic            alt
  );
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] r;
    sh = b[SHW-1:0];
    unique case (f)
      3'b000: r = alt ? a - b : a + b;
      3'b001: r = a << sh;
      3'b010: r = XLEN'($signed(a) < $signed(b));
      3'b011: r = XLEN'(a < b);
      3'b100: r = a ^ b;
      3'b101: r = alt ? XLEN'($signed(a) >>> sh) : a >> sh;
      3'b110: r = a | b;
      3'b111: r = a & b;
    endcase
    return r;
  endfunction

  // 32-bit ops whose result is sign-extended to the full register
  function automatic logic [XLEN-1:0] aluw(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  f,
    input logic        alt
  );
    logic [31:0] r;
    unique case (f)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      default: r = '0;
    endcase
    return XLEN'($signed(r));
  endfunction

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign rd  = ir_q[11:7];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rv1 = gpr[rs1];
  assign rv2 = gpr[rs2];

  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_b = XLEN'($signed({ir_q[31], ir_q[7],
                 ir_q[30:25], ir_q[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({ir_q[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12],
                 ir_q[20], ir_q[30:21], 1'b0}));

  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign is_jal   = opc == 7'b1101111;
  assign is_jalr  = opc == 7'b1100111;
  assign is_br    = opc == 7'b1100011;
  assign is_opi   = opc == 7'b0010011;
  assign is_op    = opc == 7'b0110011;
  assign is_opiw  = (XLEN == 64) && (opc == 7'b0011011);
  assign is_opw   = (XLEN == 64) && (opc == 7'b0111011);
  assign w_ok     = (f3 == 3'b000) || (f3 == 3'b001) ||
                    (f3 == 3'b101);

  always_comb begin
    br_take = 1'b0;
    unique case (f3)
      3'b000:  br_take = rv1 == rv2;
      3'b001:  br_take = rv1 != rv2;
      3'b100:  br_take = $signed(rv1) < $signed(rv2);
      3'b101:  br_take = $signed(rv1) >= $signed(rv2);
      3'b110:  br_take = rv1 < rv2;
      3'b111:  br_take = rv1 >= rv2;
      default: br_take = 1'b0;
    endcase
  end

  always_comb begin
    res   = '0;
    wen   = 1'b0;
    jump  = 1'b0;
    jaddr = pc_q + imm_b;
    unique case (1'b1)
      is_lui: begin
        res = imm_u;
        wen = 1'b1;
      end
      is_auipc: begin
        res = pc_q + imm_u;
        wen = 1'b1;
      end
      is_jal: begin
        res   = pc_q + XLEN'(4);
        wen   = 1'b1;
        jump  = 1'b1;
        jaddr = pc_q + imm_j;
      end
      is_jalr: begin
        res   = pc_q + XLEN'(4);
        wen   = 1'b1;
        jump  = 1'b1;
        jaddr = (rv1 + imm_i) & ~XLEN'(1);
      end
      is_br: jump = br_take;
      is_opi: begin
        res = alu(rv1, imm_i, f3,
                  (f3 == 3'b101) && ir_q[30]);
        wen = 1'b1;
      end
      is_op: begin
        res = alu(rv1, rv2, f3, ir_q[30]);
        wen = 1'b1;
      end
      is_opiw: begin
        res = aluw(rv1[31:0], imm_i[31:0], f3,
                   (f3 == 3'b101) && ir_q[30]);
        wen = w_ok;
      end
      is_opw: begin
        res = aluw(rv1[31:0], rv2[31:0], f3, ir_q[30]);
        wen = w_ok;
      end
      default: ;
    endcase
  end

  assign npc       = jump ? jaddr : pc_q + XLEN'(4);
  assign wr_rd     = (wen && rd != 5'd0) ? rd : 5'd0;
  assign timed_out = (TIMEOUT != 0) && (wait_q == 32'(TIMEOUT));

  assign imem.imem_req_addr = pc_q;

  always_comb begin
    state_d             = state_q;
    imem.imem_req_valid = 1'b0;
    unique case (state_q)
      IF_REQ: begin
        imem.imem_req_valid = 1'b1;
        if (imem.imem_req_ready) state_d = IF_WAIT;
      end
      IF_WAIT: begin
        if (imem.imem_rsp_valid) state_d = EXE;
        else if (timed_out)      state_d = HALT;
      end
      EXE:     state_d = WB;
      WB:      state_d = (ir_q == EBREAK) ? HALT : IF_REQ;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IF_REQ;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q         <= RESET_PC[XLEN-1:0];
      npc_q        <= '0;
      ir_q         <= '0;
      wait_q       <= '0;
      halt         <= 1'b0;
      fetch_err    <= 1'b0;
      commit_valid <= 1'b0;
      commit_pc    <= '0;
      commit_inst  <= '0;
      commit_rd    <= '0;
      commit_wdata <= '0;
    end else begin
      commit_valid <= 1'b0;
      unique case (state_q)
        IF_REQ: wait_q <= '0;
        IF_WAIT: begin
          if (imem.imem_rsp_valid) begin
            ir_q <= imem.imem_rsp_inst;
          end else if (timed_out) begin
            halt      <= 1'b1;
            fetch_err <= 1'b1;
          end else begin
            wait_q <= wait_q + 32'd1;
          end
        end
        EXE: begin
          commit_valid <= 1'b1;
          commit_pc    <= pc_q;
          commit_inst  <= ir_q;
          commit_rd    <= wr_rd;
          commit_wdata <= (wr_rd != 5'd0) ? res : '0;
          npc_q        <= npc;
        end
        WB: begin
          if (ir_q == EBREAK) halt <= 1'b1;
          else                pc_q <= npc_q;
        end
        default: ;
      endcase
    end
  end

  // x0 is never written, so it reads zero without a special case
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (state_q == WB && commit_rd != 5'd0) begin
      gpr[commit_rd] <= commit_wdata;
    end
  end
endmodule
